// File: rtl/walk_pkg.sv
// Shared definitions for the walk-request bank: arbiter state encoding and
// default sizing constants used by the top level and the per-channel latch.
// No ports; imported with `import walk_pkg::*`.
package walk_pkg;

    // Arbiter states: waiting for a request, offering a grant, serviced and
    // waiting for the sequencer to clear the granted channel.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_CLR = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DEBOUNCE = 3;

    // Debounce counter width; enough for DEBOUNCE up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/walk_request_bank_if.sv
// Bundle of button, clear, grant-handshake and status signals between the
// synchroniser/sequencer side (master) and the walk-request bank (slave).
// Ports: wr_sync, wr_reset, svc_ready toward the bank; wr_out, grant_*,
// pending_cnt from the bank.
interface walk_request_bank_if #(
    parameter int NUM_CH = 4
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] wr_sync;
    logic [NUM_CH-1:0] wr_reset;
    logic              svc_ready;
    logic [NUM_CH-1:0] wr_out;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic              grant_busy;
    logic [ID_W:0]     pending_cnt;

    modport master (
        output wr_sync, wr_reset, svc_ready,
        input  wr_out, grant_valid, grant_id, grant_busy, pending_cnt
    );

    modport slave (
        input  wr_sync, wr_reset, svc_ready,
        output wr_out, grant_valid, grant_id, grant_busy, pending_cnt
    );

endinterface

// File: rtl/walk_debounce_latch.sv
// One pedestrian channel: debounce counter, armed flag and latched request bit.
// Ports: clk, rst_i (sync active-high), wr_sync_i (button level),
// wr_reset_i (clear), wr_out_o (latched request).
module walk_debounce_latch
    import walk_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_i,
    input  logic wr_sync_i,
    input  logic wr_reset_i,
    output logic wr_out_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             wr_q, wr_d;
    logic             set_w;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        set_w   = 1'b0;
        if (!wr_sync_i) begin
            // Any low cycle restarts the count and re-arms the channel.
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                // DEBOUNCE-th consecutive high cycle: latch once, then disarm
                // so a held button cannot re-trigger.
                set_w   = 1'b1;
                armed_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A fresh press beats a simultaneous clear so it is never lost.
        wr_d = set_w | (wr_q & ~wr_reset_i);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
            wr_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            wr_q    <= wr_d;
        end
    end

    assign wr_out_o = wr_q;

endmodule

// File: rtl/walk_request_bank.sv
// NUM_CH debounced walk-request latches plus a round-robin arbiter that offers
// one pending channel at a time to the light sequencer.
// Ports: clk, g_reset (sync active-high), bus (walk_request_bank_if.slave).
module walk_request_bank
    import walk_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                  clk,
    input  logic                  g_reset,
    walk_request_bank_if.slave    bus
);

    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] wr_out_w;

    // ---------------- per-channel latches ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        walk_debounce_latch #(
            .DEBOUNCE (DEBOUNCE)
        ) u_latch (
            .clk        (clk),
            .rst_i      (g_reset),
            .wr_sync_i  (bus.wr_sync[g]),
            .wr_reset_i (bus.wr_reset[g]),
            .wr_out_o   (wr_out_w[g])
        );
    end

    // ---------------- pending count ----------------
    logic [ID_W:0] pending_w;

    always_comb begin
        pending_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pending_w = pending_w + (ID_W+1)'(wr_out_w[i]);
        end
    end

    // ---------------- round-robin pick ----------------
    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    logic [ID_W:0]   cand;

    // Scan offsets from farthest to nearest so the channel closest after
    // last_grant is the final (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = {1'b0, last_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_CH)) begin
                cand = cand - (ID_W+1)'(NUM_CH);
            end
            if (wr_out_w[cand[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[ID_W-1:0];
            end
        end
    end

    // ---------------- arbiter FSM ----------------
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_id_d = pick_id;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (bus.svc_ready) begin
                    state_d = WAIT_CLR;
                end else if (bus.wr_reset[grant_id_q]) begin
                    // Cleared elsewhere before acceptance: withdraw the offer
                    // without advancing the round-robin pointer.
                    state_d = IDLE;
                end
            end
            WAIT_CLR: begin
                if (bus.wr_reset[grant_id_q]) begin
                    last_d  = grant_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (g_reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= ID_W'(NUM_CH - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
        end
    end

    assign bus.wr_out      = wr_out_w;
    assign bus.pending_cnt = pending_w;
    assign bus.grant_valid = (state_q == OFFER);
    assign bus.grant_busy  = (state_q == WAIT_CLR);
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_walk_request_bank.sv
// Self-checking bench for walk_request_bank: directed checks plus a queue of
// expected grant ids compared when each grant is offered.
module tb_walk_request_bank;

    localparam int NUM_CH = 4;

    logic clk;
    logic g_reset;

    walk_request_bank_if #(.NUM_CH(NUM_CH)) bus ();

    walk_request_bank #(
        .NUM_CH   (NUM_CH),
        .DEBOUNCE (3)
    ) dut (
        .clk     (clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive mask high for n cycles, then one low cycle.
    task automatic press(input logic [NUM_CH-1:0] mask, input int n);
        bus.wr_sync = mask;
        repeat (n) step();
        bus.wr_sync = '0;
        step();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.grant_valid && n < 50) begin
            step();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    endtask

    // Wait for an offer, compare it with the scoreboard head, accept it and clear it.
    task automatic serve_one(input string tag);
        int exp;
        logic [1:0] id;
        wait_valid(tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            exp = -1;
        end else begin
            exp = exp_q.pop_front();
        end
        check_eq({tag, "_id"}, 32'(bus.grant_id), 32'(exp));
        id = bus.grant_id;
        bus.svc_ready = 1'b1;
        step();
        bus.svc_ready = 1'b0;
        check_eq({tag, "_busy"}, 32'(bus.grant_busy), 32'd1);
        check_eq({tag, "_accept_vld"}, 32'(bus.grant_valid), 32'd0);
        bus.wr_reset = '0;
        bus.wr_reset[id] = 1'b1;
        step();
        bus.wr_reset = '0;
        check_eq({tag, "_cleared"}, 32'(bus.wr_out[id]), 32'd0);
        check_eq({tag, "_idle"}, 32'(bus.grant_busy), 32'd0);
    endtask

    initial begin
        g_reset       = 1'b1;
        bus.wr_sync   = '0;
        bus.wr_reset  = '0;
        bus.svc_ready = 1'b0;
        repeat (3) step();

        // ---- reset state ----
        check_eq("rst_wr_out", 32'(bus.wr_out), 32'd0);
        check_eq("rst_valid", 32'(bus.grant_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.grant_busy), 32'd0);
        check_eq("rst_id", 32'(bus.grant_id), 32'd0);
        check_eq("rst_pending", 32'(bus.pending_cnt), 32'd0);

        // ---- latency: ch1 high cycles 0..2 ----
        g_reset     = 1'b0;
        bus.wr_sync = 4'b0010;
        step();
        check_eq("lat_c1", 32'(bus.wr_out), 32'd0);
        step();
        check_eq("lat_c2", 32'(bus.wr_out), 32'd0);
        step();
        bus.wr_sync = '0;
        check_eq("lat_c3_wr", 32'(bus.wr_out), 32'b0010);
        check_eq("lat_c3_pend", 32'(bus.pending_cnt), 32'd1);
        check_eq("lat_c3_vld", 32'(bus.grant_valid), 32'd0);
        step();
        check_eq("lat_c4_vld", 32'(bus.grant_valid), 32'd1);
        check_eq("lat_c4_id", 32'(bus.grant_id), 32'd1);
        exp_q.push_back(1);
        serve_one("lat_srv");

        // ---- glitch and hold on ch2 ----
        press(4'b0100, 2);
        repeat (3) step();
        check_eq("glitch", 32'(bus.wr_out), 32'd0);
        bus.wr_sync = 4'b0100;
        repeat (3) step();
        check_eq("hold_set", 32'(bus.wr_out), 32'b0100);
        exp_q.push_back(2);
        serve_one("hold_srv");
        repeat (10) step();
        check_eq("hold_noreset", 32'(bus.wr_out), 32'd0);
        check_eq("hold_novld", 32'(bus.grant_valid), 32'd0);
        bus.wr_sync = '0;
        step();
        bus.wr_sync = 4'b0100;
        repeat (2) step();
        check_eq("rearm_2", 32'(bus.wr_out), 32'd0);
        step();
        check_eq("rearm_3", 32'(bus.wr_out), 32'b0100);
        bus.wr_sync = '0;
        exp_q.push_back(2);
        serve_one("rearm_srv");

        // ---- handshake stall on ch0 ----
        press(4'b0001, 3);
        wait_valid("hs");
        for (int i = 0; i < 5; i++) begin
            check_eq("hs_stall_vld", 32'(bus.grant_valid), 32'd1);
            check_eq("hs_stall_id", 32'(bus.grant_id), 32'd0);
            step();
        end
        bus.svc_ready = 1'b1;
        step();
        bus.svc_ready = 1'b0;
        check_eq("hs_busy", 32'(bus.grant_busy), 32'd1);
        check_eq("hs_vld0", 32'(bus.grant_valid), 32'd0);
        step();
        check_eq("hs_busy_hold", 32'(bus.grant_busy), 32'd1);
        bus.wr_reset = 4'b0001;
        step();
        bus.wr_reset = '0;
        check_eq("hs_clr", 32'(bus.wr_out), 32'd0);
        check_eq("hs_idle", 32'(bus.grant_busy), 32'd0);

        // ---- round robin from a fresh reset ----
        g_reset = 1'b1;
        step();
        g_reset = 1'b0;
        press(4'b1111, 3);
        check_eq("rr_all", 32'(bus.wr_out), 32'hF);
        check_eq("rr_pend", 32'(bus.pending_cnt), 32'd4);
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(2); exp_q.push_back(3);
        for (int i = 0; i < 4; i++) serve_one("rr4");
        press(4'b0101, 3);
        exp_q.push_back(0); exp_q.push_back(2);
        serve_one("rr2");
        serve_one("rr2");

        // ---- external clear while offering: pointer stays at 2 ----
        press(4'b0010, 3);
        wait_valid("ext");
        check_eq("ext_id", 32'(bus.grant_id), 32'd1);
        bus.wr_reset = 4'b0010;
        step();
        bus.wr_reset = '0;
        check_eq("ext_vld", 32'(bus.grant_valid), 32'd0);
        check_eq("ext_busy", 32'(bus.grant_busy), 32'd0);
        check_eq("ext_wr", 32'(bus.wr_out), 32'd0);
        press(4'b0101, 3);
        exp_q.push_back(0); exp_q.push_back(2);
        serve_one("ext_srv");
        serve_one("ext_srv");

        // ---- set/clear collision on ch3 ----
        press(4'b1000, 3);
        wait_valid("col");
        check_eq("col_id", 32'(bus.grant_id), 32'd3);
        bus.wr_sync = 4'b1000;
        repeat (2) step();
        bus.wr_reset = 4'b1000;
        step();
        bus.wr_reset = '0;
        bus.wr_sync  = '0;
        check_eq("col_set_wins", 32'(bus.wr_out[3]), 32'd1);
        exp_q.push_back(3);
        serve_one("col_srv");

        // ---- reset during WAIT_CLR ----
        press(4'b1010, 3);
        wait_valid("mr");
        check_eq("mr_id", 32'(bus.grant_id), 32'd1);
        bus.svc_ready = 1'b1;
        step();
        bus.svc_ready = 1'b0;
        check_eq("mr_busy", 32'(bus.grant_busy), 32'd1);
        check_eq("mr_wr", 32'(bus.wr_out), 32'b1010);
        g_reset = 1'b1;
        step();
        g_reset = 1'b0;
        check_eq("mr_wr0", 32'(bus.wr_out), 32'd0);
        check_eq("mr_busy0", 32'(bus.grant_busy), 32'd0);
        check_eq("mr_vld0", 32'(bus.grant_valid), 32'd0);
        press(4'b0011, 3);
        exp_q.push_back(0); exp_q.push_back(1);
        serve_one("mr_srv");
        serve_one("mr_srv");

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/walk_request_bank.md
Name: walk_request_bank

Overview:
- Multi-channel successor to the single walk-request latch in the traffic-light controller.
- Each of NUM_CH pedestrian channels gets:
  - a debounced, edge-armed request latch;
  - a per-channel clear from the sequencer.
- A round-robin arbiter offers one pending channel at a time to the light sequencer over a valid/ready grant handshake.
- Sits between the button synchronisers and the light-sequencing FSM.

Parameters:
- NUM_CH, 4: number of walk-request channels (2..16).
- DEBOUNCE, 3: consecutive high cycles of wr_sync needed to register a press (1..15). A value of 1 means single-cycle latching.
- ID_W, $clog2(NUM_CH): width of grant_id (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- g_reset  in  1  synchronous reset, active-high.
- wr_sync  in  NUM_CH  already-synchronised button levels, one bit per channel.
- wr_reset  in  NUM_CH  per-channel clear of the latched request (request served).
- svc_ready  in  1  sequencer ready to accept the offered grant.
- wr_out  out  NUM_CH  latched pending requests.
- grant_valid  out  1  a grant is being offered.
- grant_id  out  ID_W  channel being offered or serviced.
- grant_busy  out  1  a grant has been accepted and is awaiting its wr_reset.
- pending_cnt  out  ID_W+1  popcount of wr_out (combinational from wr_out).

Behaviour:
- Reset (g_reset=1 at a clk edge):
  - wr_out=0, all debounce counters=0, all armed flags=1;
  - state=IDLE, grant_valid=0, grant_busy=0, grant_id=0;
  - last_grant=NUM_CH-1, so channel 0 has first priority.
  - Reset mid-grant abandons the grant silently; no wr_reset is required afterwards.
- Per-channel debounce:
  - While wr_sync[i]=1 and armed[i]=1, the counter increments; when wr_sync[i]=0, the counter and armed[i] are reset to 0 and 1.
  - On the DEBOUNCE-th consecutive high cycle, wr_out[i] sets at that edge and armed[i] clears.
  - Latency: wr_sync high in cycles 0..DEBOUNCE-1 gives wr_out visible from cycle DEBOUNCE.
  - A held button sets the request exactly once. Re-arming requires at least one low cycle.
  - A glitch shorter than DEBOUNCE never sets the request.
- Clear:
  - wr_reset[i]=1 clears wr_out[i] at the next edge.
  - If a set and a clear for the same channel fall in the same cycle, the set wins (a new press is never lost).
  - wr_reset on a channel that is not pending has no effect.
- Arbiter FSM, states IDLE / OFFER / WAIT_CLR:
  - IDLE: if wr_out is nonzero, select the first set bit scanning upward from last_grant+1, modulo NUM_CH. Register grant_id and go to OFFER, so grant_valid rises one cycle after wr_out.
  - OFFER: grant_valid=1; grant_id is held stable until the handshake.
    - If svc_ready=1, go to WAIT_CLR: grant_valid=0, grant_busy=1.
    - If wr_reset[grant_id]=1 arrives before svc_ready (external clear), return to IDLE with no handshake; last_grant is unchanged.
  - WAIT_CLR: grant_busy=1.
    - On wr_reset[grant_id]=1, set last_grant=grant_id and return to IDLE.
    - Earliest next offer is 2 cycles after the clear edge.
    - Other channels keep latching and clearing independently in all states.
- Boundaries:
  - All channels pending: service order is strictly round-robin.
  - A single channel re-pressed after service may be re-granted only when no other channel is pending.
  - wr_reset for a channel other than grant_id during WAIT_CLR clears only that channel.

Decomposition:
- Shared package walk_pkg holds:
  - the arbiter state enum (IDLE, OFFER, WAIT_CLR);
  - the default NUM_CH and DEBOUNCE constants.
- One natural sub-module: walk_debounce_latch, a single channel's counter, armed flag and wr_out bit, instantiated NUM_CH times in a generate loop.
- The round-robin arbiter and FSM stay in the top module.

Test Plan:
- Reset/latency: release g_reset, then ch1 wr_sync high for 3 cycles. Required: wr_out=4'b0010 at cycle 3, grant_valid=1 with grant_id=1 at cycle 4, pending_cnt=1.
- Glitch and hold:
  - ch2 high for 2 cycles: wr_out stays 0.
  - ch2 then held high for 20 cycles: wr_out[2] sets once.
  - After service-clear while still held: wr_out[2] stays 0 until a low cycle and 3 new high cycles.
- Handshake:
  - Offer ch0 with svc_ready=0 for 5 cycles: grant_id stays 0 and grant_valid stays 1.
  - svc_ready=1: grant_busy=1 and grant_valid=0 next cycle.
  - wr_reset[0]: wr_out[0]=0, then IDLE.
- Round-robin: latch all 4 channels together and serve each promptly. Required: grant order 0,1,2,3. Re-press ch0 and ch2, then serve: order 0,2.
- Set/clear collision: wr_reset[3] and the 3rd debounce cycle of ch3 in the same cycle. Required: wr_out[3]=1 afterwards.
- Reset mid-operation: assert g_reset during WAIT_CLR for ch1 with wr_out=4'b1010. Required: next cycle wr_out=0, grant_busy=0, grant_valid=0, and the next grant goes to channel 0 first.
